i2c_master_driver: RTL and testbench
====================================

I2C_MASTER_DRIVER -- requirements
Module: i2c_master_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, meaning system clocks per SCL quarter-period (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_start  input  1  one-cycle pulse launching a transfer.
REQ-005 SHALL have port i_chip_addr  input  7  target address, sampled at i_start.
REQ-006 SHALL have port i_rw  input  1  1 = read, 0 = write, sampled at i_start.
REQ-007 SHALL have port i_nb_data  input  8  number of data bytes, sampled at i_start.
REQ-008 SHALL have port i_wdata  input  8  write byte, sampled on the cycle o_wdata_req is high.
REQ-009 SHALL have port o_wdata_req  output  1  one-cycle pulse requesting the next write byte.
REQ-010 SHALL have port o_rdata  output  8  last received byte.
REQ-011 SHALL have port o_rdata_valid  output  1  one-cycle pulse, o_rdata updated.
REQ-012 SHALL have port o_busy  output  1  high from the i_start acceptance cycle until STOP completes.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse at transfer end.
REQ-014 SHALL have port o_nack_err  output  1  sticky slave-NACK flag, cleared on next accepted i_start.
REQ-015 SHALL have port scl  inout  1  open-drain: driven 0 or Z only.
REQ-016 SHALL have port sda  inout  1  open-drain: driven 0 or Z only.

Function
REQ-017 SHALL generate a quarter tick every CLK_DIV clocks while busy; one SCL bit = 4 ticks (Q0,Q1 SCL low; Q2,Q3 SCL released).
REQ-018 SHALL change SDA only at Q0 and sample SDA at the Q2 tick (SCL rising edge).
REQ-019 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, MACK, STOP.
REQ-020 IDLE: SCL and SDA released; i_start accepted -> START; i_start while busy SHALL be ignored.
REQ-021 START: SDA pulled low while SCL released for 2 ticks, then SCL low -> ADDR.
REQ-022 ADDR: shift {i_chip_addr, i_rw} out MSB first over 8 bits -> ADDR_ACK.
REQ-023 ADDR_ACK: release SDA; sampled 1 -> set o_nack_err, go STOP; sampled 0 with i_nb_data = 0 -> STOP; else WR_BYTE (rw=0) or RD_BYTE (rw=1).
REQ-024 WR_BYTE: pulse o_wdata_req once, 1 cycle before the byte's first Q0; shift the byte out MSB first -> WR_ACK.
REQ-025 WR_ACK: sampled 1 -> o_nack_err, STOP; byte count reached -> STOP; else WR_BYTE.
REQ-026 RD_BYTE: release SDA, shift in 8 bits MSB first; pulse o_rdata_valid on the tick sampling bit 0 -> MACK.
REQ-027 MACK: drive SDA 0 (ACK) if more bytes remain, release (NACK) on the last byte; then RD_BYTE or STOP.
REQ-028 STOP: SDA low with SCL low, release SCL, release SDA 2 ticks later, pulse o_done, -> IDLE.
REQ-029 SHALL count bytes with an 8-bit counter compared to the latched i_nb_data; 255 bytes is the maximum, no wrap.
REQ-030 SHALL treat SCL as not stretched (no clock-stretch wait).
REQ-031 o_busy SHALL deassert in the same cycle as the o_done pulse.

Reset
REQ-032 On rst_n low, SHALL release scl/sda immediately (combinationally from reset), state IDLE, all counters 0.
REQ-033 Reset values: o_wdata_req 0, o_rdata 0x00, o_rdata_valid 0, o_busy 0, o_done 0, o_nack_err 0.
REQ-034 Reset mid-transfer SHALL abort without STOP generation or an o_done pulse.

Structure
REQ-035 SHALL place the state enum and bit/quarter constants in shared package i2c_pkg, shared with the slave-side checker.
REQ-036 SHALL instantiate one sub-module i2c_tick_gen (quarter-tick divider, enable-gated).

Verification
REQ-037 Write 2 bytes to 0x50 with data 0xA5, 0x3C and a checker ACKing -> bus shows 0xA0, 0xA5, 0x3C, STOP; o_wdata_req pulses 2x; o_done 1x; o_nack_err 0.
REQ-038 Read 3 bytes from 0x50 with slave returning 0x11, 0x22, 0x33 -> o_rdata_valid 3x with those values; ACK, ACK, NACK; STOP.
REQ-039 Address 0x51 with no slave responding (SDA pulled up) -> o_nack_err 1 after 9th SCL; STOP; o_done.
REQ-040 i_nb_data = 0 to 0x50 -> START, 0xA0, ACK, STOP; no o_wdata_req.
REQ-041 rst_n low mid-byte during a write -> scl/sda Z in the same cycle, o_busy 0, no o_done; next i_start works.
REQ-042 CLK_DIV = 2 and i_start pulsed while busy -> SCL period 8 clocks; second i_start ignored.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared I2C definitions: controller state encoding, SCL
//                quarter-period indices and byte-framing constants. Used by
//                the master driver and by slave-side checkers.
//  Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

    // Controller states
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_ADDR_ACK = 4'd3,
        ST_WR_BYTE  = 4'd4,
        ST_WR_ACK   = 4'd5,
        ST_RD_BYTE  = 4'd6,
        ST_MACK     = 4'd7,
        ST_STOP     = 4'd8
    } i2c_state_e;

    // Quarter index within one SCL bit: Q0/Q1 SCL low, Q2/Q3 SCL released
    localparam logic [1:0] c_q0 = 2'd0;
    localparam logic [1:0] c_q1 = 2'd1;
    localparam logic [1:0] c_q2 = 2'd2;
    localparam logic [1:0] c_q3 = 2'd3;

    // Index of the last data bit of a byte (bits counted 0..7, MSB first)
    localparam logic [2:0] c_last_bit = 3'd7;

    // Width of the quarter-period divider counter (CLK_DIV up to 65535)
    localparam int c_div_w = 16;

    // First byte on the bus after START: 7-bit address plus R/W flag
    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_tick_gen
//  Description : Quarter-period tick divider. Free-runs while enabled and
//                restarts from zero whenever disabled. Also flags the cycle
//                immediately before each tick.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_tick_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam logic [c_div_w-1:0] c_last = c_div_w'(CLK_DIV - 1);
    localparam logic [c_div_w-1:0] c_pre  = c_div_w'(CLK_DIV - 2);

    logic [c_div_w-1:0] r_cnt;

    // Divider counter: wraps at CLK_DIV-1, held at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick     = i_en && (r_cnt == c_last);
    assign o_pre_tick = i_en && (r_cnt == c_pre);

endmodule
`default_nettype wire

// File: rtl/i2c_master_driver.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_master_driver
//  Description : Single-master I2C controller. Issues START, address + R/W,
//                a programmable number of write or read bytes, and STOP on
//                open-drain SCL/SDA. No clock stretching.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_master_driver
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [6:0] i_chip_addr,
    input  logic       i_rw,
    input  logic [7:0] i_nb_data,
    input  logic [7:0] i_wdata,
    output logic       o_wdata_req,
    output logic [7:0] o_rdata,
    output logic       o_rdata_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack_err,
    inout  wire        scl,
    inout  wire        sda
);

    i2c_state_e r_state, w_state_nxt;
    logic [1:0] r_q,     w_q_nxt;
    logic [2:0] r_bit,   w_bit_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [6:0] r_addr,  w_addr_nxt;
    logic       r_rw,    w_rw_nxt;
    logic [7:0] r_nb,    w_nb_nxt;
    logic [7:0] r_cnt,   w_cnt_nxt;
    logic [7:0] r_wdata, w_wdata_nxt;
    logic       r_ack,   w_ack_nxt;
    logic       r_scl_oe, w_scl_oe_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_done,  w_done_nxt;
    logic       r_nack_err, w_nack_err_nxt;
    logic [7:0] r_rdata, w_rdata_nxt;
    logic       r_rdata_valid, w_rdata_valid_nxt;
    logic       w_wdata_req;

    logic       w_tick;
    logic       w_pre_tick;
    logic       w_sda_in;
    logic       w_framed;
    logic [7:0] w_addr_byte;
    logic [7:0] w_rd_byte;

    i2c_tick_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (r_busy),
        .o_tick     (w_tick),
        .o_pre_tick (w_pre_tick)
    );

    // Open-drain pads: pull low or release; reset releases without waiting for a clock
    assign scl      = (rst_n && r_scl_oe) ? 1'b0 : 1'bz;
    assign sda      = (rst_n && r_sda_oe) ? 1'b0 : 1'bz;
    assign w_sda_in = sda;

    assign w_framed    = (r_state != ST_IDLE) && (r_state != ST_START);
    assign w_addr_byte = addr_byte(r_addr, r_rw);
    assign w_rd_byte   = {r_shift[6:0], w_sda_in};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_q           <= c_q0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_addr        <= '0;
            r_rw          <= 1'b0;
            r_nb          <= '0;
            r_cnt         <= '0;
            r_wdata       <= '0;
            r_ack         <= 1'b0;
            r_scl_oe      <= 1'b0;
            r_sda_oe      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_nack_err    <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_q           <= w_q_nxt;
            r_bit         <= w_bit_nxt;
            r_shift       <= w_shift_nxt;
            r_addr        <= w_addr_nxt;
            r_rw          <= w_rw_nxt;
            r_nb          <= w_nb_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wdata       <= w_wdata_nxt;
            r_ack         <= w_ack_nxt;
            r_scl_oe      <= w_scl_oe_nxt;
            r_sda_oe      <= w_sda_oe_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_nack_err    <= w_nack_err_nxt;
            r_rdata       <= w_rdata_nxt;
            r_rdata_valid <= w_rdata_valid_nxt;
        end
    end

    // Next-state, bus drive and handshake decode
    always_comb begin
        w_state_nxt       = r_state;
        w_q_nxt           = r_q;
        w_bit_nxt         = r_bit;
        w_shift_nxt       = r_shift;
        w_addr_nxt        = r_addr;
        w_rw_nxt          = r_rw;
        w_nb_nxt          = r_nb;
        w_cnt_nxt         = r_cnt;
        w_wdata_nxt       = r_wdata;
        w_ack_nxt         = r_ack;
        w_scl_oe_nxt      = r_scl_oe;
        w_sda_oe_nxt      = r_sda_oe;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        w_nack_err_nxt    = r_nack_err;
        w_rdata_nxt       = r_rdata;
        w_rdata_valid_nxt = 1'b0;
        w_wdata_req       = 1'b0;

        // Common bit timing: SCL pulled low at Q0, released at Q2
        if (w_framed && w_tick) begin
            if (r_q == c_q3) begin
                w_q_nxt      = c_q0;
                w_scl_oe_nxt = 1'b1;
            end else begin
                w_q_nxt = r_q + 2'd1;
                if (r_q == c_q1) begin
                    w_scl_oe_nxt = 1'b0;
                end
            end
        end

        case (r_state)
            ST_IDLE: begin
                w_scl_oe_nxt = 1'b0;
                w_sda_oe_nxt = 1'b0;
                if (i_start) begin
                    w_addr_nxt     = i_chip_addr;
                    w_rw_nxt       = i_rw;
                    w_nb_nxt       = i_nb_data;
                    w_cnt_nxt      = '0;
                    w_nack_err_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                    w_q_nxt        = c_q0;
                    w_sda_oe_nxt   = 1'b1;          // START: SDA falls while SCL high
                    w_state_nxt    = ST_START;
                end
            end

            ST_START: begin
                if (w_tick) begin
                    if (r_q == c_q0) begin
                        w_q_nxt = c_q1;
                    end else begin
                        w_state_nxt  = ST_ADDR;
                        w_q_nxt      = c_q0;
                        w_scl_oe_nxt = 1'b1;
                        w_bit_nxt    = '0;
                        w_shift_nxt  = w_addr_byte;
                        w_sda_oe_nxt = ~w_addr_byte[7];
                    end
                end
            end

            ST_ADDR, ST_WR_BYTE: begin
                if (w_tick && (r_q == c_q3)) begin
                    if (r_bit == c_last_bit) begin
                        w_sda_oe_nxt = 1'b0;         // let the slave answer
                        w_bit_nxt    = '0;
                        if (r_state == ST_ADDR) begin
                            w_state_nxt = ST_ADDR_ACK;
                        end else begin
                            w_state_nxt = ST_WR_ACK;
                            w_cnt_nxt   = r_cnt + 8'd1;
                        end
                    end else begin
                        w_bit_nxt    = r_bit + 3'd1;
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                        w_sda_oe_nxt = ~r_shift[6];
                    end
                end
            end

            ST_ADDR_ACK, ST_WR_ACK: begin
                if (w_tick && (r_q == c_q1)) begin
                    w_ack_nxt = w_sda_in;
                end
                // Ask for the next write byte one cycle ahead of its first Q0
                if ((r_q == c_q3) && w_pre_tick && !r_ack) begin
                    if (r_state == ST_ADDR_ACK) begin
                        w_wdata_req = !r_rw && (r_nb != 8'd0);
                    end else begin
                        w_wdata_req = (r_cnt != r_nb);
                    end
                end
                if (w_tick && (r_q == c_q3)) begin
                    w_bit_nxt = '0;
                    if (r_ack) begin
                        w_nack_err_nxt = 1'b1;
                        w_state_nxt    = ST_STOP;
                        w_sda_oe_nxt   = 1'b1;
                    end else if (((r_state == ST_ADDR_ACK) && (r_nb == 8'd0)) ||
                                 ((r_state == ST_WR_ACK) && (r_cnt == r_nb))) begin
                        w_state_nxt  = ST_STOP;
                        w_sda_oe_nxt = 1'b1;
                    end else if ((r_state == ST_ADDR_ACK) && r_rw) begin
                        w_state_nxt  = ST_RD_BYTE;
                        w_sda_oe_nxt = 1'b0;
                    end else begin
                        w_state_nxt  = ST_WR_BYTE;
                        w_shift_nxt  = r_wdata;
                        w_sda_oe_nxt = ~r_wdata[7];
                    end
                end
            end

            ST_RD_BYTE: begin
                w_sda_oe_nxt = 1'b0;
                if (w_tick && (r_q == c_q1)) begin
                    w_shift_nxt = w_rd_byte;
                    if (r_bit == c_last_bit) begin
                        w_rdata_nxt       = w_rd_byte;
                        w_rdata_valid_nxt = 1'b1;
                        w_cnt_nxt         = r_cnt + 8'd1;
                    end
                end
                if (w_tick && (r_q == c_q3)) begin
                    if (r_bit == c_last_bit) begin
                        w_state_nxt  = ST_MACK;
                        w_bit_nxt    = '0;
                        w_sda_oe_nxt = (r_cnt != r_nb);   // ACK unless last byte
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end

            ST_MACK: begin
                if (w_tick && (r_q == c_q3)) begin
                    if (r_cnt == r_nb) begin
                        w_state_nxt  = ST_STOP;
                        w_sda_oe_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_RD_BYTE;
                        w_sda_oe_nxt = 1'b0;
                    end
                end
            end

            ST_STOP: begin
                // SCL released at Q2 by common timing; SDA rises two ticks later
                if (w_tick && (r_q == c_q3)) begin
                    w_scl_oe_nxt = 1'b0;
                    w_sda_oe_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_scl_oe_nxt = 1'b0;
                w_sda_oe_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
            end
        endcase

        if (w_wdata_req) begin
            w_wdata_nxt = i_wdata;
        end
    end

    assign o_wdata_req   = w_wdata_req;
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_nack_err    = r_nack_err;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_master_driver
//  Description : Self-checking bench: bus monitor + ACKing slave model at
//                7-bit address 0x50, scoreboard queues for bus events,
//                write-data supply and read data.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_master_driver;

    localparam int         DIV      = 2;
    localparam logic [6:0] SLV_ADDR = 7'h50;
    localparam int         PH_IDLE  = 0;
    localparam int         PH_ADDR  = 1;
    localparam int         PH_WR    = 2;
    localparam int         PH_RD    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [6:0] i_chip_addr = 7'h00;
    logic       i_rw = 1'b0;
    logic [7:0] i_nb_data = 8'h00;
    logic [7:0] i_wdata = 8'h00;
    logic       o_wdata_req;
    logic [7:0] o_rdata;
    logic       o_rdata_valid;
    logic       o_busy;
    logic       o_done;
    logic       o_nack_err;
    wire        scl;
    wire        sda;
    logic       slv_low = 1'b0;

    pullup (scl);
    pullup (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master_driver #(
        .CLK_DIV       (DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_chip_addr   (i_chip_addr),
        .i_rw          (i_rw),
        .i_nb_data     (i_nb_data),
        .i_wdata       (i_wdata),
        .o_wdata_req   (o_wdata_req),
        .o_rdata       (o_rdata),
        .o_rdata_valid (o_rdata_valid),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_nack_err    (o_nack_err),
        .scl           (scl),
        .sda           (sda)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int n_wreq = 0;

    // Scoreboard queues. Bus events: 3000 START, 4000 STOP, 10xx byte, 200a ack bit
    logic [15:0] ev_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  wd_q[$];
    logic [7:0]  tx_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_ev(input logic [15:0] code);
        if (ev_q.size() == 0) chk("bus_unexpected_event", 32'(code), 32'h0);
        else                  chk("bus_event", 32'(code), 32'(ev_q.pop_front()));
    endtask

    task automatic exp_byte(input logic [7:0] b, input logic ack);
        ev_q.push_back({8'h10, b});
        ev_q.push_back({15'h1000, ack});
    endtask

    // Monitor, slave model and handshake responders
    int         k = 0;
    int         ph = PH_IDLE;
    int         cyc = 0;
    int         last_rise = 0;
    logic       pscl = 1'b1;
    logic       psda = 1'b1;
    logic       mack = 1'b0;
    logic [7:0] sh = 8'h00;
    logic [7:0] tx = 8'hFF;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            k = 0; ph = PH_IDLE; slv_low = 1'b0; pscl = 1'b1; psda = 1'b1;
        end else begin
            if (o_wdata_req) begin
                n_wreq++;
                if (wd_q.size() > 0) i_wdata = wd_q.pop_front();
                else chk("wdata_req_unexpected", 32'd1, 32'd0);
            end
            if (o_rdata_valid) begin
                if (rd_q.size() > 0) chk("rdata", 32'(o_rdata), 32'(rd_q.pop_front()));
                else chk("rdata_valid_unexpected", 32'd1, 32'd0);
            end
            if (o_done) begin
                n_done++;
                chk("busy_low_with_done", 32'(o_busy), 32'd0);
            end
            if (pscl && scl && psda && !sda) begin
                bus_ev(16'h3000);
                k = 0; ph = PH_ADDR; slv_low = 1'b0;
            end else if (pscl && scl && !psda && sda) begin
                bus_ev(16'h4000);
                ph = PH_IDLE; slv_low = 1'b0;
            end else if (!pscl && scl) begin
                if (k < 8) sh = {sh[6:0], sda};
                else begin
                    mack = sda;
                    bus_ev({15'h1000, sda});
                end
                k++;
                if (k == 8) bus_ev({8'h10, sh});
                if (k == 4) chk("scl_period_clocks", 32'(cyc - last_rise), 32'(4 * DIV));
                last_rise = cyc;
            end else if (pscl && !scl) begin
                if (k == 9) begin
                    k = 0;
                    if (ph == PH_ADDR) begin
                        if (sh[7:1] != SLV_ADDR) ph = PH_IDLE;
                        else ph = sh[0] ? PH_RD : PH_WR;
                        if (ph == PH_RD) tx = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
                    end else if (ph == PH_RD) begin
                        if (mack) ph = PH_IDLE;
                        else tx = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hFF;
                    end
                end
                slv_low = 1'b0;
                if (k == 8 && ((ph == PH_ADDR && sh[7:1] == SLV_ADDR) || ph == PH_WR)) slv_low = 1'b1;
                else if (k < 8 && ph == PH_RD) slv_low = !tx[7-k];
            end
            pscl = scl;
            psda = sda;
        end
    end

    // One transfer; optional second i_start pulse while busy at cycle 'extra'
    task automatic xfer(input logic [6:0] a, input logic rw, input logic [7:0] nb,
                        input logic exp_nack, input int exp_wreq, input int extra);
        int d0;
        int w0;
        d0 = n_done;
        w0 = n_wreq;
        @(negedge clk);
        i_chip_addr = a; i_rw = rw; i_nb_data = nb; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", 32'(o_busy), 32'd1);
        chk("nack_cleared_on_start", 32'(o_nack_err), 32'd0);
        for (int i = 0; i < 4000 && n_done == d0; i++) begin
            if (i == extra) begin
                i_chip_addr = 7'h33; i_rw = 1'b1; i_nb_data = 8'd7; i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
        chk("done_pulses", 32'(n_done - d0), 32'd1);
        repeat (4) @(negedge clk);
        chk("done_pulses_settled", 32'(n_done - d0), 32'd1);
        chk("nack_err", 32'(o_nack_err), 32'(exp_nack));
        chk("wdata_req_pulses", 32'(n_wreq - w0), 32'(exp_wreq));
        chk("bus_events_left", 32'(ev_q.size()), 32'd0);
        chk("rdata_left", 32'(rd_q.size()), 32'd0);
        chk("idle_scl", 32'(scl), 32'd1);
        chk("idle_sda", 32'(sda), 32'd1);
    endtask

    initial begin
        int d0;
        int w0;
        int i;
        repeat (3) @(negedge clk);
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_nack", 32'(o_nack_err), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk("rst_rvalid", 32'(o_rdata_valid), 32'd0);
        chk("rst_wreq", 32'(o_wdata_req), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Write 0xA5, 0x3C to 0x50
        ev_q.push_back(16'h3000); exp_byte(8'hA0, 1'b0); exp_byte(8'hA5, 1'b0);
        exp_byte(8'h3C, 1'b0); ev_q.push_back(16'h4000);
        wd_q.push_back(8'hA5); wd_q.push_back(8'h3C);
        xfer(7'h50, 1'b0, 8'd2, 1'b0, 2, -1);

        // Read 3 bytes from 0x50: master ACK, ACK, NACK
        tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
        ev_q.push_back(16'h3000); exp_byte(8'hA1, 1'b0); exp_byte(8'h11, 1'b0);
        exp_byte(8'h22, 1'b0); exp_byte(8'h33, 1'b1); ev_q.push_back(16'h4000);
        rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
        xfer(7'h50, 1'b1, 8'd3, 1'b0, 0, -1);

        // No slave at 0x51
        ev_q.push_back(16'h3000); exp_byte(8'hA2, 1'b1); ev_q.push_back(16'h4000);
        xfer(7'h51, 1'b0, 8'd1, 1'b1, 0, -1);

        // Zero data bytes
        ev_q.push_back(16'h3000); exp_byte(8'hA0, 1'b0); ev_q.push_back(16'h4000);
        xfer(7'h50, 1'b0, 8'd0, 1'b0, 0, -1);

        // Second i_start while busy must be ignored
        ev_q.push_back(16'h3000); exp_byte(8'hA0, 1'b0); exp_byte(8'h5A, 1'b0);
        ev_q.push_back(16'h4000);
        wd_q.push_back(8'h5A);
        xfer(7'h50, 1'b0, 8'd1, 1'b0, 1, 40);

        // Reset in the middle of a data byte
        ev_q.push_back(16'h3000); exp_byte(8'hA0, 1'b0); exp_byte(8'h96, 1'b0);
        wd_q.push_back(8'h96); wd_q.push_back(8'h66);
        d0 = n_done;
        w0 = n_wreq;
        @(negedge clk);
        i_chip_addr = 7'h50; i_rw = 1'b0; i_nb_data = 8'd2; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (i = 0; i < 2000 && n_wreq == w0; i++) @(negedge clk);
        chk("reset_test_wreq_seen", 32'(n_wreq - w0), 32'd1);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_scl", 32'(scl), 32'd1);
        chk("midreset_sda", 32'(sda), 32'd1);
        chk("midreset_busy", 32'(o_busy), 32'd0);
        chk("midreset_done", 32'(o_done), 32'd0);
        ev_q.delete();
        wd_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("no_done_after_reset", 32'(n_done - d0), 32'd0);
        chk("no_bus_activity_after_reset", 32'(ev_q.size()), 32'd0);

        // Normal transfer after the abort
        ev_q.push_back(16'h3000); exp_byte(8'hA0, 1'b0); exp_byte(8'hC3, 1'b0);
        ev_q.push_back(16'h4000);
        wd_q.push_back(8'hC3);
        xfer(7'h50, 1'b0, 8'd1, 1'b0, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
